// File: rtl/sqrt_remainder_pipe_if.sv
// Valid/ready stream bundle for the pipelined square-root unit: radicand and tag
// in, root/remainder and tag out.
interface sqrt_remainder_pipe_if #(
  parameter int unsigned RADICAND_WIDTH = 16,
  parameter int unsigned TAG_WIDTH      = 4
);
  localparam int unsigned ROOT_W = RADICAND_WIDTH / 2;
  localparam int unsigned REM_W  = ROOT_W + 1;

  logic                      in_valid;
  logic                      in_ready;
  logic [RADICAND_WIDTH-1:0] in_radicand;
  logic [TAG_WIDTH-1:0]      in_tag;
  logic                      out_valid;
  logic                      out_ready;
  logic [ROOT_W-1:0]         out_root;
  logic [REM_W-1:0]          out_remainder;
  logic [TAG_WIDTH-1:0]      out_tag;

  modport master (
    output in_valid, in_radicand, in_tag, out_ready,
    input  in_ready, out_valid, out_root, out_remainder, out_tag
  );

  modport slave (
    input  in_valid, in_radicand, in_tag, out_ready,
    output in_ready, out_valid, out_root, out_remainder, out_tag
  );
endinterface

// File: rtl/sqrt_remainder_pipe.sv
// Fully pipelined unsigned integer square root with remainder (non-restoring
// digit recurrence), BITS_PER_STAGE root bits per register stage, global stall.
module sqrt_remainder_pipe #(
  parameter int unsigned RADICAND_WIDTH = 16,
  parameter int unsigned BITS_PER_STAGE = 1,
  parameter int unsigned TAG_WIDTH      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sqrt_remainder_pipe_if.slave bus,
  output logic                 busy
);

  localparam int unsigned ROOT_W     = RADICAND_WIDTH / 2;
  localparam int unsigned REM_W      = ROOT_W + 1;
  localparam int unsigned NUM_STAGES = ROOT_W / BITS_PER_STAGE;
  localparam int unsigned LAST       = NUM_STAGES - 1;

  // rem is a REM_W+1 bit two's-complement partial remainder
  typedef struct packed {
    logic [RADICAND_WIDTH-1:0] rad;
    logic [REM_W:0]            rem;
    logic [ROOT_W-1:0]         root;
  } work_t;

  function automatic work_t resolve_bits(input work_t s);
    work_t          t;
    logic [REM_W:0] r;
    t = s;
    for (int unsigned b = 0; b < BITS_PER_STAGE; b++) begin
      r = {t.rem[REM_W-2:0], t.rad[RADICAND_WIDTH-1 -: 2]};
      if (t.rem[REM_W]) r = r + {t.root, 2'b11};
      else              r = r - {t.root, 2'b01};
      t.root = {t.root[ROOT_W-2:0], ~r[REM_W]};
      t.rem  = r;
      t.rad  = {t.rad[RADICAND_WIDTH-3:0], 2'b00};
    end
    return t;
  endfunction

  work_t                stage_q [NUM_STAGES];
  work_t                stage_d [NUM_STAGES];
  logic [TAG_WIDTH-1:0] tag_q   [NUM_STAGES];
  logic [TAG_WIDTH-1:0] tag_d   [NUM_STAGES];
  logic [NUM_STAGES-1:0] valid_q, valid_d;
  work_t                stage_in;
  logic                 advance;

  always_comb begin
    advance        = ~valid_q[LAST] | bus.out_ready;
    stage_in       = '0;
    stage_in.rad   = bus.in_radicand;
    stage_d[0]     = resolve_bits(stage_in);
    tag_d[0]       = bus.in_tag;
    valid_d        = '0;
    valid_d[0]     = bus.in_valid & advance;
    for (int unsigned k = 1; k < NUM_STAGES; k++) begin
      stage_d[k]   = resolve_bits(stage_q[k-1]);
      tag_d[k]     = tag_q[k-1];
      valid_d[k]   = valid_q[k-1];
    end
    // Undo the last failed trial subtraction: add back 2*root+1, which equals
    // {root_before_last_bit, 01} since the final root bit is 0 here.
    if (stage_d[LAST].rem[REM_W]) begin
      stage_d[LAST].rem = stage_d[LAST].rem + {1'b0, stage_d[LAST].root, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        stage_q[k] <= '0;
        tag_q[k]   <= '0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        stage_q[k] <= stage_d[k];
        tag_q[k]   <= tag_d[k];
      end
    end
  end

  assign bus.in_ready      = advance;
  assign bus.out_valid     = valid_q[LAST];
  assign bus.out_root      = stage_q[LAST].root;
  assign bus.out_remainder = stage_q[LAST].rem[REM_W-1:0];
  assign bus.out_tag       = tag_q[LAST];
  assign busy              = |valid_q;

endmodule
